program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Boot stage upstream of the processor/RAM pair. Receives a framed byte stream, assembles words,
//   writes them into SinglePortRam and holds the processor in reset until the image is complete.
// - Frame: START_ADDR, COUNT (0 => 2**ADDRESS_WIDTH words), COUNT words MSB-byte-first, CHECKSUM.
// - CHECKSUM = XOR of every preceding byte in the frame.
// PARAMETERS
// - WORD_WIDTH     Isa::INSTRUCTION_SIZE (16)      RAM word width; must be a multiple of 8
// - ADDRESS_WIDTH  Isa::MEMORY_ADDRESS_WIDTH (8)   RAM address width; wraps modulo 2**ADDRESS_WIDTH
// PORTS
// - i_clock            in   1              clock; all logic on posedge
// - i_reset            in   1              synchronous reset, active-high
// - i_start            in   1              1-cycle pulse: begin receiving a frame (IDLE/DONE/ERROR only)
// - i_byte             in   8              stream data
// - i_valid            in   1              i_byte valid
// - o_ready            out  1              loader accepts i_byte this cycle (transfer = i_valid & o_ready)
// - o_ram_write_enable out  1              one-cycle RAM write strobe
// - o_ram_address      out  ADDRESS_WIDTH  RAM write address
// - o_ram_write_data   out  WORD_WIDTH     RAM write data
// - o_core_hold        out  1              1 = keep processor in reset
// - o_done             out  1              frame loaded, checksum good (level)
// - o_error            out  1              checksum mismatch (level)
// BEHAVIOUR
// - Reset: state IDLE; o_ready=0, o_ram_write_enable=0, o_ram_address=0, o_ram_write_data=0,
//   o_core_hold=1, o_done=0, o_error=0, checksum=0, counters=0. Reset mid-frame aborts; RAM keeps
//   any words already written.
// - States: IDLE -> ADDRESS -> COUNT -> DATA (BYTES_PER_WORD bytes) -> WRITE -> {DATA | CHECKSUM}
//   -> DONE | ERROR.
// - IDLE/DONE/ERROR: o_ready=0; i_start -> ADDRESS, clears o_done/o_error/checksum, sets o_core_hold=1.
//   i_start is ignored in every other state.
// - ADDRESS, COUNT, DATA, CHECKSUM: o_ready=1. Each transfer XORs into checksum, except the CHECKSUM
//   byte itself. The state holds while i_valid=0.
// - ADDRESS: latch o_ram_address. COUNT: latch count; 0 means 2**ADDRESS_WIDTH words.
// - DATA: shift bytes in MSB first. After the last byte of a word -> WRITE.
// - WRITE: exactly one cycle, o_ready=0, o_ram_write_enable=1, data stable. Next cycle the address
//   increments (wraps max->0) and the remaining count decrements. Remaining=0 -> CHECKSUM,
//   else -> DATA.
// - Write latency: the last byte of a word is accepted at edge N; the strobe is high during cycle N+1.
// - CHECKSUM: byte == accumulated XOR -> DONE (o_done=1, o_core_hold=0). Otherwise -> ERROR
//   (o_error=1, o_core_hold stays 1).
// - o_done and o_error are never both 1. o_core_hold is low only in DONE.
// - Max throughput: 1 word per BYTES_PER_WORD+1 cycles.
// STRUCTURE
// - Isa package: WORD_WIDTH/ADDRESS_WIDTH defaults only. The loader state enum stays local (not shared).
// - BYTES_PER_WORD = WORD_WIDTH/8 is a localparam. Byte-lane counter is $clog2(BYTES_PER_WORD) bits,
//   min 1. Word counter is ADDRESS_WIDTH+1 bits.
// - Single module; no sub-module. Top level connects the o_ram_* ports to a RamPort write modport.
// TESTING
// - Basic: start; bytes 00 01 12 34 27 -> one strobe, addr 00, data 1234; o_done=1, o_core_hold=0.
// - Bad checksum: same frame with final byte 00 -> no further writes; o_error=1, o_core_hold=1, o_done=0.
// - Wrap: addr FF, count 02, words AAAA 5555, checksum FD -> writes mem[FF]=AAAA then mem[00]=5555.
// - Full image: count 00, 256 words -> 256 strobes, addresses 00..FF in order, then DONE.
// - Backpressure: random i_valid gaps, plus i_valid held high through WRITE -> no byte lost or
//   duplicated; o_ready=0 in WRITE.
// - Reset mid-DATA, then a new start with a good frame -> IDLE state, hold=1; the new image loads
//   correctly and the partial word is discarded.
// - i_start pulsed during DATA -> ignored, frame completes normally. Restart from DONE re-asserts
//   o_core_hold the following cycle.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared ISA sizing defaults for the boot loader and the processor/RAM pair it feeds.
package program_loader_pkg;

  localparam int unsigned DEFAULT_WORD_WIDTH    = 16;
  localparam int unsigned DEFAULT_ADDRESS_WIDTH = 8;

endpackage

// File: rtl/program_loader.sv
// Boot loader: receives a framed byte stream, writes the assembled words into RAM and
// holds the processor in reset until the image arrives with a valid XOR checksum.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DEFAULT_WORD_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [7:0]               i_byte,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] o_ram_address,
  output logic [WORD_WIDTH-1:0]    o_ram_write_data,
  output logic                     o_core_hold,
  output logic                     o_done,
  output logic                     o_error
);

  localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int unsigned LANE_WIDTH     = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned COUNT_WIDTH    = ADDRESS_WIDTH + 1;

  localparam logic [LANE_WIDTH-1:0]  LAST_LANE  = LANE_WIDTH'(BYTES_PER_WORD - 1);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDRESS,
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECKSUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [WORD_WIDTH-1:0]    word_q, word_d;
  logic [7:0]               checksum_q, checksum_d;
  logic [COUNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic [LANE_WIDTH-1:0]    lane_q, lane_d;
  logic                     ready_q, ready_d;
  logic                     write_enable_q, write_enable_d;
  logic                     hold_q, hold_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     transfer;

  assign transfer = i_valid & ready_q;

  // Next-state and datapath update; ready/strobe are decoded from the next state so they are registered.
  always_comb begin
    state_d        = state_q;
    address_d      = address_q;
    word_d         = word_q;
    checksum_d     = checksum_q;
    remaining_d    = remaining_q;
    lane_d         = lane_q;
    hold_d         = hold_q;
    done_d         = done_q;
    error_d        = error_q;
    ready_d        = 1'b0;
    write_enable_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start) begin
          state_d    = S_ADDRESS;
          checksum_d = 8'h00;
          lane_d     = '0;
          hold_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
        end
      end
      S_ADDRESS: begin
        if (transfer) begin
          address_d  = ADDRESS_WIDTH'(i_byte);
          checksum_d = checksum_q ^ i_byte;
          state_d    = S_COUNT;
        end
      end
      S_COUNT: begin
        if (transfer) begin
          remaining_d = (i_byte == 8'h00) ? FULL_COUNT : COUNT_WIDTH'(i_byte);
          checksum_d  = checksum_q ^ i_byte;
          lane_d      = '0;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (transfer) begin
          word_d     = (word_q << 8) | WORD_WIDTH'(i_byte);
          checksum_d = checksum_q ^ i_byte;
          if (lane_q == LAST_LANE) begin
            lane_d  = '0;
            state_d = S_WRITE;
          end else begin
            lane_d = lane_q + LANE_WIDTH'(1);
          end
        end
      end
      S_WRITE: begin
        address_d   = address_q + ADDRESS_WIDTH'(1);
        remaining_d = remaining_q - COUNT_WIDTH'(1);
        state_d     = (remaining_q == COUNT_WIDTH'(1)) ? S_CHECKSUM : S_DATA;
      end
      S_CHECKSUM: begin
        if (transfer) begin
          if (i_byte == checksum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_ADDRESS) || (state_d == S_COUNT) ||
              (state_d == S_DATA)    || (state_d == S_CHECKSUM);
    write_enable_d = (state_d == S_WRITE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      address_q      <= '0;
      word_q         <= '0;
      checksum_q     <= 8'h00;
      remaining_q    <= '0;
      lane_q         <= '0;
      ready_q        <= 1'b0;
      write_enable_q <= 1'b0;
      hold_q         <= 1'b1;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      address_q      <= address_d;
      word_q         <= word_d;
      checksum_q     <= checksum_d;
      remaining_q    <= remaining_d;
      lane_q         <= lane_d;
      ready_q        <= ready_d;
      write_enable_q <= write_enable_d;
      hold_q         <= hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign o_ready            = ready_q;
  assign o_ram_write_enable = write_enable_q;
  assign o_ram_address      = address_q;
  assign o_ram_write_data   = word_q;
  assign o_core_hold        = hold_q;
  assign o_done             = done_q;
  assign o_error            = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: frames are driven byte by byte and every RAM strobe
// is matched against a scoreboard of expected (address, data) writes.
module tb_program_loader;

  logic        i_clock;
  logic        i_reset;
  logic        i_start;
  logic [7:0]  i_byte;
  logic        i_valid;
  logic        o_ready;
  logic        o_ram_write_enable;
  logic [7:0]  o_ram_address;
  logic [15:0] o_ram_write_data;
  logic        o_core_hold;
  logic        o_done;
  logic        o_error;

  program_loader dut (
    .i_clock            (i_clock),
    .i_reset            (i_reset),
    .i_start            (i_start),
    .i_byte             (i_byte),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_ram_write_enable (o_ram_write_enable),
    .o_ram_address      (o_ram_address),
    .o_ram_write_data   (o_ram_write_data),
    .o_core_hold        (o_core_hold),
    .o_done             (o_done),
    .o_error            (o_error)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] tx_words[256];
  int          n_checks = 0;
  int          n_errors = 0;

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Presents one byte after an optional idle gap and waits until the loader takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int   guard;
    logic taken;
    if (gap > 0) begin
      i_valid = 1'b0;
      repeat (gap) tick();
    end
    i_byte  = b;
    i_valid = 1'b1;
    taken   = 1'b0;
    guard   = 0;
    while (!taken && guard < 64) begin
      taken = o_ready;
      tick();
      guard++;
    end
    if (!taken) check("byte_timeout", 32'(0), 32'(1));
  endtask

  task automatic pulse_start();
    i_valid = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt, input bit bad,
                            input int gap_max, input bit start_mid);
    logic [7:0]  cs;
    logic [7:0]  wa;
    logic [15:0] w;
    int          n;
    pulse_start();
    check("hold_after_start", 32'(o_core_hold), 32'(1));
    check("done_cleared_on_start", 32'(o_done), 32'(0));
    check("error_cleared_on_start", 32'(o_error), 32'(0));
    cs = addr ^ cnt;
    wa = addr;
    n  = (cnt == 8'h00) ? 256 : int'(cnt);
    send_byte(addr, int'($urandom_range(0, gap_max)));
    send_byte(cnt, int'($urandom_range(0, gap_max)));
    for (int i = 0; i < n; i++) begin
      w = tx_words[i];
      exp_q.push_back('{addr: wa, data: w});
      wa = wa + 8'd1;
      send_byte(w[15:8], int'($urandom_range(0, gap_max)));
      cs = cs ^ w[15:8];
      if (start_mid && i == 0) pulse_start();
      send_byte(w[7:0], int'($urandom_range(0, gap_max)));
      cs = cs ^ w[7:0];
      check("write_latency", 32'(o_ram_write_enable), 32'(1));
    end
    send_byte(bad ? ~cs : cs, int'($urandom_range(0, gap_max)));
    i_valid = 1'b0;
    tick();
    tick();
    check("done", 32'(o_done), bad ? 32'(0) : 32'(1));
    check("error", 32'(o_error), bad ? 32'(1) : 32'(0));
    check("core_hold", 32'(o_core_hold), bad ? 32'(1) : 32'(0));
    check("ready_after_frame", 32'(o_ready), 32'(0));
    check("writes_drained", 32'(exp_q.size()), 32'(0));
  endtask

  // Scoreboard and invariant monitor, sampled away from the active edge.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_done && o_error) check("done_error_exclusive", 32'(1), 32'(0));
      if (!o_core_hold && !o_done) check("hold_low_only_in_done", 32'(0), 32'(1));
      if (o_ram_write_enable) begin
        wr_t e;
        check("ready_in_write", 32'(o_ready), 32'(0));
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(o_ram_address), 32'(e.addr));
          check("write_data", 32'(o_ram_write_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_byte  = 8'h00;
    i_valid = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(o_ready), 32'(0));
    check("rst_we", 32'(o_ram_write_enable), 32'(0));
    check("rst_addr", 32'(o_ram_address), 32'(0));
    check("rst_data", 32'(o_ram_write_data), 32'(0));
    check("rst_hold", 32'(o_core_hold), 32'(1));
    check("rst_done", 32'(o_done), 32'(0));
    check("rst_error", 32'(o_error), 32'(0));
    i_reset = 1'b0;
    tick();

    // Basic frame: 00 01 12 34 27.
    tx_words[0] = 16'h1234;
    send_frame(8'h00, 8'h01, 1'b0, 0, 1'b0);

    // Same frame with a corrupted checksum; restart from DONE.
    send_frame(8'h00, 8'h01, 1'b1, 0, 1'b0);

    // Address wrap FF -> 00.
    tx_words[0] = 16'hAAAA;
    tx_words[1] = 16'h5555;
    send_frame(8'hFF, 8'h02, 1'b0, 0, 1'b0);

    // Random valid gaps and an ignored start pulse during DATA.
    for (int i = 0; i < 8; i++) tx_words[i] = 16'($urandom);
    send_frame(8'h40, 8'h08, 1'b0, 3, 1'b1);

    // Reset in the middle of a word, then a clean frame.
    pulse_start();
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    send_byte(8'hEE, 0);
    i_valid = 1'b0;
    i_reset = 1'b1;
    tick();
    tick();
    check("midrst_hold", 32'(o_core_hold), 32'(1));
    check("midrst_ready", 32'(o_ready), 32'(0));
    check("midrst_addr", 32'(o_ram_address), 32'(0));
    check("midrst_done", 32'(o_done), 32'(0));
    i_reset = 1'b0;
    tick();
    tx_words[0] = 16'h1357;
    tx_words[1] = 16'h2468;
    tx_words[2] = 16'h0F0F;
    send_frame(8'h20, 8'h03, 1'b0, 1, 1'b0);

    // Full 256-word image with valid held high through every write.
    for (int i = 0; i < 256; i++) tx_words[i] = 16'($urandom);
    send_frame(8'h00, 8'h00, 1'b0, 0, 1'b0);

    repeat (4) tick();
    check("no_stray_writes", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
